// File: rtl/street_light_array_ctrl.sv
// -----------------------------------------------------------------------------
// street_light_array_ctrl
//
// Adaptive streetlight controller for an array of N_CH lamps.
// - Each lamp is off by day and dim at night.
// - A lamp goes bright while its own vehicle sensor fires. With LOOKAHEAD set,
//   the upstream neighbour's sensor also fires it.
// - Bright is held for HOLD_CYC cycles after the last trigger.
// - Lamp levels ramp toward their target by at most RAMP_STEP per cycle.
// - A shared free-running counter turns each level into a PWM drive.
// - A debounced night flag and an R/G/B status lamp summarise the array.
//
// Ports:
//   clk         in   1            system clock, rising edge
//   rst         in   1            asynchronous active-high reset
//   day         in   1            ambient light sensor, 1 = daylight
//   veh_detect  in   N_CH         per-channel vehicle sensor, level-sensitive
//   lamp_pwm    out  N_CH         per-channel PWM lamp drive (registered)
//   lamp_level  out  N_CH*PWM_W   current level; channel i at [i*PWM_W +: PWM_W]
//   night       out  1            debounced night flag
//   R           out  1            some channel is BRIGHT
//   G           out  1            daytime
//   B           out  1            night and no channel BRIGHT
// -----------------------------------------------------------------------------
module street_light_array_ctrl #(
    parameter int N_CH      = 4,
    parameter int PWM_W     = 8,
    parameter int DIM_LVL   = 64,
    parameter int FULL_LVL  = 255,
    parameter int RAMP_STEP = 8,
    parameter int HOLD_CYC  = 100,
    parameter int DEBOUNCE  = 4,
    parameter int LOOKAHEAD = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    day,
    input  logic [N_CH-1:0]         veh_detect,
    output logic [N_CH-1:0]         lamp_pwm,
    output logic [N_CH*PWM_W-1:0]   lamp_level,
    output logic                    night,
    output logic                    R,
    output logic                    G,
    output logic                    B
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'd0,
        ST_DIM    = 2'd1,
        ST_BRIGHT = 2'd2
    } ch_state_e;

    localparam int HOLD_W  = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
    localparam int DEB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE + 1) : 1;
    // A step wider than the whole level range behaves like a jump to target.
    localparam int STEP_CL = (RAMP_STEP > (2 ** PWM_W)) ? (2 ** PWM_W) : RAMP_STEP;

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYC - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE - 1);
    localparam logic [PWM_W-1:0]  DIM_V     = PWM_W'(DIM_LVL);
    localparam logic [PWM_W-1:0]  FULL_V    = PWM_W'(FULL_LVL);
    localparam logic [PWM_W:0]    STEP_V    = (PWM_W + 1)'(STEP_CL);

    // Input stage and debounce
    logic                 day_q;
    logic [N_CH-1:0]      veh_q;
    logic                 night_q,  night_d;
    logic [DEB_W-1:0]     deb_q,    deb_d;

    // Per-channel state
    logic [N_CH-1:0]      trig_s;
    ch_state_e            state_q [N_CH];
    ch_state_e            state_d [N_CH];
    logic [HOLD_W-1:0]    hold_q  [N_CH];
    logic [HOLD_W-1:0]    hold_d  [N_CH];
    logic [PWM_W-1:0]     level_q [N_CH];
    logic [PWM_W-1:0]     level_d [N_CH];

    // PWM and status
    logic [PWM_W-1:0]     pwm_cnt_q;
    logic [N_CH-1:0]      pwm_q, pwm_d;
    logic                 any_bright_s;
    logic                 r_q, g_q, b_q;

    // Register the raw sensors once; everything downstream uses the registered copies
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            day_q <= 1'b0;
            veh_q <= {N_CH{1'b0}};
        end else begin
            day_q <= day;
            veh_q <= veh_detect;
        end
    end

    // Count consecutive samples that contradict the night flag. The flag flips
    // on the edge where the count would reach DEBOUNCE.
    always_comb begin
        night_d = night_q;
        deb_d   = deb_q;
        if (day_q == night_q) begin
            if (deb_q == DEB_LAST) begin
                night_d = ~night_q;
                deb_d   = DEB_W'(0);
            end else begin
                deb_d   = deb_q + DEB_W'(1);
            end
        end else begin
            deb_d = DEB_W'(0);
        end
    end

    // Night flag and debounce counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            night_q <= 1'b0;
            deb_q   <= DEB_W'(0);
        end else begin
            night_q <= night_d;
            deb_q   <= deb_d;
        end
    end

    // Channel 0 has no upstream neighbour, so only its own sensor can trigger it
    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_trig
            if (gi == 0) begin : g_first
                assign trig_s[gi] = veh_q[gi];
            end else begin : g_rest
                assign trig_s[gi] = veh_q[gi] | ((LOOKAHEAD != 0) & veh_q[gi-1]);
            end
        end
    endgenerate

    // Per-channel OFF/DIM/BRIGHT next state and hold timer.
    // Daylight forces OFF even when a trigger arrives in the same cycle.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            state_d[i] = state_q[i];
            hold_d[i]  = hold_q[i];
            case (state_q[i])
                ST_OFF: begin
                    if (night_q) begin
                        state_d[i] = ST_DIM;
                    end else begin
                        state_d[i] = ST_OFF;
                    end
                end
                ST_DIM: begin
                    if (!night_q) begin
                        state_d[i] = ST_OFF;
                    end else if (trig_s[i]) begin
                        state_d[i] = ST_BRIGHT;
                        hold_d[i]  = HOLD_LOAD;
                    end else begin
                        state_d[i] = ST_DIM;
                    end
                end
                ST_BRIGHT: begin
                    if (!night_q) begin
                        state_d[i] = ST_OFF;
                        hold_d[i]  = HOLD_W'(0);
                    end else if (trig_s[i]) begin
                        hold_d[i]  = HOLD_LOAD;
                    end else if (hold_q[i] != HOLD_W'(0)) begin
                        hold_d[i]  = hold_q[i] - HOLD_W'(1);
                    end else begin
                        state_d[i] = ST_DIM;
                    end
                end
                default: begin
                    state_d[i] = ST_OFF;
                    hold_d[i]  = HOLD_W'(0);
                end
            endcase
        end
    end

    // Channel state and hold timer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= ST_OFF;
                hold_q[i]  <= HOLD_W'(0);
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                state_q[i] <= state_d[i];
                hold_q[i]  <= hold_d[i];
            end
        end
    end

    // Ramp each level toward its state's target. One extra bit keeps the
    // difference and step arithmetic free of wrap-around.
    always_comb begin : ramp_calc
        logic [PWM_W-1:0] tgt_lvl_v;
        logic [PWM_W:0]   cur_v;
        logic [PWM_W:0]   tgt_v;
        logic [PWM_W:0]   diff_v;
        logic [PWM_W:0]   nxt_v;
        tgt_lvl_v = PWM_W'(0);
        cur_v     = (PWM_W + 1)'(0);
        tgt_v     = (PWM_W + 1)'(0);
        diff_v    = (PWM_W + 1)'(0);
        nxt_v     = (PWM_W + 1)'(0);
        for (int i = 0; i < N_CH; i++) begin
            case (state_q[i])
                ST_OFF:    tgt_lvl_v = PWM_W'(0);
                ST_DIM:    tgt_lvl_v = DIM_V;
                ST_BRIGHT: tgt_lvl_v = FULL_V;
                default:   tgt_lvl_v = PWM_W'(0);
            endcase
            cur_v = {1'b0, level_q[i]};
            tgt_v = {1'b0, tgt_lvl_v};
            if (tgt_v > cur_v) begin
                diff_v = tgt_v - cur_v;
                if (diff_v > STEP_V) begin
                    nxt_v = cur_v + STEP_V;
                end else begin
                    nxt_v = tgt_v;
                end
            end else if (cur_v > tgt_v) begin
                diff_v = cur_v - tgt_v;
                if (diff_v > STEP_V) begin
                    nxt_v = cur_v - STEP_V;
                end else begin
                    nxt_v = tgt_v;
                end
            end else begin
                diff_v = (PWM_W + 1)'(0);
                nxt_v  = cur_v;
            end
            level_d[i] = nxt_v[PWM_W-1:0];
        end
    end

    // Level registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                level_q[i] <= PWM_W'(0);
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                level_q[i] <= level_d[i];
            end
        end
    end

    // PWM compare. A strict less-than keeps level 0 permanently dark.
    always_comb begin
        pwm_d = {N_CH{1'b0}};
        for (int i = 0; i < N_CH; i++) begin
            pwm_d[i] = (pwm_cnt_q < level_q[i]);
        end
    end

    // Free-running PWM counter and registered lamp drive
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt_q <= PWM_W'(0);
            pwm_q     <= {N_CH{1'b0}};
        end else begin
            pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
            pwm_q     <= pwm_d;
        end
    end

    // OR-reduce the channel states for the status lamp
    always_comb begin
        any_bright_s = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            any_bright_s = any_bright_s | (state_q[i] == ST_BRIGHT);
        end
    end

    // Status lamp registers, one cycle behind night and the channel states
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q <= 1'b0;
            g_q <= 1'b0;
            b_q <= 1'b0;
        end else begin
            r_q <= any_bright_s;
            g_q <= ~night_q;
            b_q <= night_q & ~any_bright_s;
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_level_out
            assign lamp_level[gi*PWM_W +: PWM_W] = level_q[gi];
        end
    endgenerate

    assign lamp_pwm = pwm_q;
    assign night    = night_q;
    assign R        = r_q;
    assign G        = g_q;
    assign B        = b_q;

endmodule

// File: tb/tb_street_light_array_ctrl.sv
module tb_street_light_array_ctrl;

    localparam int N_CH      = 4;
    localparam int PWM_W     = 8;
    localparam int DIM_LVL   = 64;
    localparam int FULL_LVL  = 255;
    localparam int RAMP_STEP = 8;
    localparam int HOLD_CYC  = 100;
    localparam int DEBOUNCE  = 4;
    localparam int LOOKAHEAD = 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  day;
    logic [N_CH-1:0]       veh_detect;
    logic [N_CH-1:0]       lamp_pwm;
    logic [N_CH*PWM_W-1:0] lamp_level;
    logic                  night, R, G, B;

    street_light_array_ctrl #(
        .N_CH(N_CH), .PWM_W(PWM_W), .DIM_LVL(DIM_LVL), .FULL_LVL(FULL_LVL),
        .RAMP_STEP(RAMP_STEP), .HOLD_CYC(HOLD_CYC), .DEBOUNCE(DEBOUNCE),
        .LOOKAHEAD(LOOKAHEAD)
    ) dut (
        .clk(clk), .rst(rst), .day(day), .veh_detect(veh_detect),
        .lamp_pwm(lamp_pwm), .lamp_level(lamp_level), .night(night),
        .R(R), .G(G), .B(B)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 = off, 1 = dim, 2 = bright
    int m_day_q, m_night, m_run, m_cnt, m_R, m_G, m_B;
    int m_veh_q [N_CH];
    int m_mode  [N_CH];
    int m_hold  [N_CH];
    int m_lvl   [N_CH];
    int m_pwm   [N_CH];

    function automatic void model_reset();
        m_day_q = 0; m_night = 0; m_run = 0; m_cnt = 0;
        m_R = 0; m_G = 0; m_B = 0;
        for (int i = 0; i < N_CH; i++) begin
            m_veh_q[i] = 0; m_mode[i] = 0; m_hold[i] = 0; m_lvl[i] = 0; m_pwm[i] = 0;
        end
    endfunction

    // One clock edge. Each quantity is updated only after every consumer of
    // its previous value has been computed.
    function automatic void model_step();
        int any_b, tgt, delta, trig;
        if (rst) begin
            model_reset();
            return;
        end
        any_b = 0;
        for (int i = 0; i < N_CH; i++) if (m_mode[i] == 2) any_b = 1;
        m_R = any_b;
        m_G = (m_night == 0) ? 1 : 0;
        m_B = (m_night != 0 && any_b == 0) ? 1 : 0;
        for (int i = 0; i < N_CH; i++) m_pwm[i] = (m_cnt < m_lvl[i]) ? 1 : 0;
        m_cnt = (m_cnt + 1) % (1 << PWM_W);
        for (int i = 0; i < N_CH; i++) begin
            tgt   = (m_mode[i] == 2) ? FULL_LVL : (m_mode[i] == 1) ? DIM_LVL : 0;
            delta = tgt - m_lvl[i];
            if (delta > RAMP_STEP)  delta = RAMP_STEP;
            if (delta < -RAMP_STEP) delta = -RAMP_STEP;
            m_lvl[i] += delta;
        end
        for (int i = 0; i < N_CH; i++) begin
            trig = m_veh_q[i];
            if (LOOKAHEAD != 0 && i > 0 && m_veh_q[i-1] != 0) trig = 1;
            if (m_night == 0) begin
                m_mode[i] = 0; m_hold[i] = 0;
            end else if (m_mode[i] == 0) begin
                m_mode[i] = 1;
            end else if (trig != 0) begin
                m_mode[i] = 2; m_hold[i] = HOLD_CYC - 1;
            end else if (m_mode[i] == 2) begin
                if (m_hold[i] > 0) m_hold[i]--;
                else m_mode[i] = 1;
            end
        end
        if ((m_day_q != 0) == (m_night != 0)) begin
            m_run++;
            if (m_run == DEBOUNCE) begin
                m_night = (m_night == 0) ? 1 : 0;
                m_run   = 0;
            end
        end else begin
            m_run = 0;
        end
        m_day_q = int'(day);
        for (int i = 0; i < N_CH; i++) m_veh_q[i] = int'(veh_detect[i]);
    endfunction

    // Compare process: every output against the model on every falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            int pv;
            pv = 0;
            for (int i = 0; i < N_CH; i++) begin
                chk($sformatf("level[%0d]", i), int'(lamp_level[i*PWM_W +: PWM_W]), m_lvl[i]);
                pv |= (m_pwm[i] << i);
            end
            chk("lamp_pwm", int'(lamp_pwm), pv);
            chk("night", int'(night), m_night);
            chk("R", int'(R), m_R);
            chk("G", int'(G), m_G);
            chk("B", int'(B), m_B);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    function automatic int lvl(input int ch);
        return int'(lamp_level[ch*PWM_W +: PWM_W]);
    endfunction

    int n, hi0, hi3, seg, dval;

    initial begin
        rst = 1'b1; day = 1'b0; veh_detect = '0;
        model_reset();
        tick(); tick();
        chk("rst_levels", int'(lamp_level), 0);
        chk("rst_pwm", int'(lamp_pwm), 0);
        chk("rst_rgb", int'({night, R, G, B}), 0);
        cmp_en = 1'b1;
        rst = 1'b0; day = 1'b1;

        // Daytime: random sensors must not light anything
        repeat (50) begin veh_detect = N_CH'($urandom); tick(); end
        chk("day_night", int'(night), 0);
        chk("day_G", int'(G), 1);
        chk("day_RB", int'({R, B}), 0);
        chk("day_levels", int'(lamp_level), 0);
        chk("day_pwm", int'(lamp_pwm), 0);
        veh_detect = '0;

        // Short dark glitches
        repeat (2) begin
            day = 1'b0; repeat (3) tick();
            day = 1'b1; repeat (10) tick();
        end
        chk("glitch_night", int'(night), 0);

        // Dusk: flag rises DEBOUNCE+1 edges after the first low sample
        day = 1'b0; n = 0;
        while (night !== 1'b1 && n < 20) begin tick(); n++; end
        chk("debounce_edges", n, DEBOUNCE + 1);
        repeat (8) tick();
        chk("ramp_dim_56", lvl(0), 56);
        tick();
        for (int i = 0; i < N_CH; i++) chk("ramp_dim_64", lvl(i), 64);
        chk("night_B", int'(B), 1);

        // Vehicle on sensor 1: channels 1 and 2 go bright, then hold, then dim
        for (int t = 1; t <= 140; t++) begin
            veh_detect = (t <= 10) ? 4'b0010 : 4'b0000;
            tick();
            if (t == 25)  chk("up_t25", lvl(1), 248);
            if (t == 26) begin
                chk("up_t26_ch1", lvl(1), 255);
                chk("up_t26_ch2", lvl(2), 255);
                chk("up_t26_ch0", lvl(0), 64);
                chk("up_t26_ch3", lvl(3), 64);
                chk("up_R", int'(R), 1);
                chk("up_B", int'(B), 0);
            end
            if (t == 111) chk("hold_t111", lvl(1), 255);
            if (t == 112) chk("down_t112", lvl(1), 247);
            if (t == 134) chk("down_t134", lvl(2), 71);
            if (t == 135) chk("down_t135", lvl(1), 64);
        end

        // PWM duty at the dim level
        hi0 = 0; hi3 = 0;
        repeat (256) begin tick(); hi0 += int'(lamp_pwm[0]); hi3 += int'(lamp_pwm[3]); end
        chk("duty_ch0", hi0, 64);
        chk("duty_ch3", hi3, 64);

        // All bright, then daybreak: all OFF together and ramp to 0
        veh_detect = '1;
        repeat (30) tick();
        for (int i = 0; i < N_CH; i++) chk("all_bright", lvl(i), 255);
        veh_detect = '0; day = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 37) for (int i = 0; i < N_CH; i++) chk("off_t37", lvl(i), 7);
            if (t == 38) begin
                for (int i = 0; i < N_CH; i++) chk("off_t38", lvl(i), 0);
                chk("off_G", int'(G), 1);
            end
        end

        // Asynchronous reset mid-ramp
        day = 1'b0; veh_detect = '1;
        repeat (12) tick();
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("arst_levels", int'(lamp_level), 0);
        chk("arst_pwm", int'(lamp_pwm), 0);
        chk("arst_flags", int'({night, R, G, B}), 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("post_rst_level", lvl(0), 0);

        // Randomised traffic, day/night segments with glitches, sporadic resets
        seg = 0; dval = 0;
        repeat (4000) begin
            if (seg == 0) begin
                dval = 1 - dval;
                seg  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6))
                                                   : int'($urandom_range(20, 300));
            end
            seg--;
            day = dval[0];
            for (int i = 0; i < N_CH; i++) veh_detect[i] = ($urandom_range(0, 9) == 0);
            rst = ($urandom_range(0, 1499) == 0);
            tick();
        end
        rst = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/street_light_array_ctrl.md
Name: street_light_array_ctrl

Overview:
Parametrised multi-lamp adaptive streetlight controller driving N_CH lamp channels with PWM dimming. Each channel is off by day, dim at night, and bright while its own or the upstream neighbour's vehicle sensor fires, holding bright for a programmable time. Brightness ramps between levels. A debounced day/night flag and R/G/B status lamp summarise array state for the pole controller.

Parameters:
N_CH, 4, number of lamp channels (>=1)
PWM_W, 8, level / PWM counter width
DIM_LVL, 64, night idle level (<= 2^PWM_W-1)
FULL_LVL, 255, vehicle-present level (DIM_LVL <= FULL_LVL <= 2^PWM_W-1)
RAMP_STEP, 8, max level change per cycle (>=1)
HOLD_CYC, 100, bright hold time after last trigger, cycles (>=1)
DEBOUNCE, 4, consecutive samples needed to flip night (>=1)
LOOKAHEAD, 1, 1 = veh_detect[i-1] also triggers channel i; 0 = own sensor only

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
day  in  1  ambient light sensor, 1 = daylight
veh_detect  in  N_CH  per-channel vehicle sensor, level-sensitive
lamp_pwm  out  N_CH  per-channel PWM lamp drive
lamp_level  out  N_CH*PWM_W  current level, channel i at [i*PWM_W +: PWM_W]
night  out  1  debounced night flag
R  out  1  any channel BRIGHT
G  out  1  daytime (~night)
B  out  1  night and no channel BRIGHT

Behaviour:
- Reset (async, rst=1): all outputs 0, all levels 0, all FSMs OFF, PWM counter 0, debounce counter 0, hold counters 0, input registers 0.
- Input stage: day and veh_detect registered once (day_q, veh_q); all logic uses registered values.
- Night debounce: counter counts consecutive day_q samples disagreeing with night (day_q == night); resets to 0 on agreement. Reaching DEBOUNCE toggles night on that edge and clears counter. Glitches shorter than DEBOUNCE samples have no effect.
- trig[i] = veh_q[i] | (LOOKAHEAD & i>0 & veh_q[i-1]); channel 0 has no upstream.
- Per-channel FSM, states OFF / DIM / BRIGHT:
  - OFF: night=1 -> DIM.
  - DIM: night=0 -> OFF; else trig -> BRIGHT, hold=HOLD_CYC-1.
  - BRIGHT: night=0 -> OFF (overrides trig); trig -> reload hold=HOLD_CYC-1; else hold>0 -> hold-1; hold==0 & !trig -> DIM.
- Target: OFF 0, DIM DIM_LVL, BRIGHT FULL_LVL. Each cycle, level moves toward target by min(RAMP_STEP, |target-level|), computed in PWM_W+1 bits, no overflow/underflow, never overshoots. Retargeting mid-ramp continues from current level.
- PWM: shared free-running PWM_W-bit counter, wraps 2^PWM_W-1 -> 0. lamp_pwm[i] registered, = (cnt < level[i]); level 0 -> constant 0.
- Status: R, G, B registered from the previous cycle's night and state vector. G=1 first cycle after reset release (night=0).
- Latency: veh_detect high before edge k -> veh_q at k -> BRIGHT at k+1 -> level first rises at k+2 -> lamp_pwm reflects it at k+3.
- Simultaneous events: night fall and trig same cycle -> OFF. Reset mid-ramp -> level 0 immediately.

Test Plan:
- Reset then day=1 for 50 cycles -> night=0, G=1, R=B=0, all lamp_level=0, lamp_pwm=0.
- day 1->0 held -> night=1 exactly DEBOUNCE+1 edges after first low sample; levels ramp 0->64 in 8 cycles; B=1; day low pulses of 3 cycles give no night change.
- Night, veh_detect[1]=1 for 10 cycles, LOOKAHEAD=1 -> channels 1 and 2 BRIGHT, 64->255 in 24 cycles; channels 0,3 stay 64; R=1, B=0.
- Drop veh_detect[1] -> channels 1,2 stay at 255 for 100 cycles, then DIM, ramp to 64 in 24 cycles; re-trigger at hold=50 reloads to 99.
- Night, all channels BRIGHT, day=1 held -> after debounce all OFF same cycle, ramp 255->0 in 32 cycles, G=1.
- Level 64: over 256 cycles lamp_pwm high exactly 64 cycles; assert rst mid-ramp -> all outputs 0 asynchronously, OFF after release.
